// File: rtl/cond_pkg.sv
// Shared encodings for the condition-execution unit: condition codes, flag bit
// positions in the status register, and IT sequencer state.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_t;

  // Inverted form of a condition, used for the else-slots of an IT block.
  function automatic logic [3:0] cond_invert(input logic [3:0] code);
    return code ^ 4'd1;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of one condition code against a {Z,C,N,V} flag set.
// Zero latency; no flow control.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] code,
  input  logic [3:0] flags,
  output logic       pass
);

  logic z, c, n, v;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (code)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Status register, per-lane condition evaluation with 1-cycle registered results,
// and an IT-block sequencer built only when COND_IT_BLOCK_EN is defined. No backpressure.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int IT_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flag_we,
  input  logic [3:0]         flag_mask,
  input  logic [3:0]         flag_in,
  output logic [3:0]         status_out,
  input  logic [LANES-1:0]   ev_valid,
  input  logic [4*LANES-1:0] ev_cond,
  output logic [LANES-1:0]   ev_done,
  output logic [LANES-1:0]   ev_pass,
  input  logic               it_load,
  input  logic [3:0]         it_cond,
  input  logic [1:0]         it_len,
  input  logic [3:0]         it_then,
  output logic               it_active
);

  logic [3:0]         status_q;
  logic [4*LANES-1:0] eff_cond;
  logic [LANES-1:0]   lane_pass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= 4'b0000;
    end else if (flag_we) begin
      status_q <= (status_q & ~flag_mask) | (flag_in & flag_mask);
    end
  end

  assign status_out = status_q;

  // Lanes always see the pre-write status; a flag write lands one cycle later.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cond_eval u_eval (
      .code  (eff_cond[4*g +: 4]),
      .flags (status_q),
      .pass  (lane_pass[g])
    );
  end

`ifdef COND_IT_BLOCK_EN
  localparam int CW = 4;
  localparam int SW = $clog2(IT_MAX);

  it_state_t         it_state;
  logic [CW-1:0]     it_ptr;
  logic [CW-1:0]     it_len_q;
  logic [3:0]        it_cond_q;
  logic [IT_MAX-1:0] it_then_q;
  logic [CW-1:0]     consumed;
  logic [CW-1:0]     slot;
  logic              it_active_q;

  // Slots fill in lane order, so the running count of consumed slots equals
  // the number of valid lanes below i until the block runs out.
  always_comb begin
    eff_cond = ev_cond;
    consumed = '0;
    slot     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (it_state == IT_ACTIVE && ev_valid[i] && (it_ptr + consumed < it_len_q)) begin
        slot = it_ptr + consumed;
        eff_cond[4*i +: 4] = it_then_q[slot[SW-1:0]] ? it_cond_q : cond_invert(it_cond_q);
        consumed = consumed + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      it_state    <= IT_IDLE;
      it_ptr      <= '0;
      it_len_q    <= '0;
      it_cond_q   <= 4'd0;
      it_then_q   <= '0;
      it_active_q <= 1'b0;
    end else if (it_load) begin
      it_state    <= IT_ACTIVE;
      it_ptr      <= '0;
      it_len_q    <= CW'(it_len) + CW'(1);
      it_cond_q   <= it_cond;
      it_then_q   <= IT_MAX'(it_then);
      it_active_q <= 1'b1;
    end else if (it_state == IT_ACTIVE) begin
      if (it_ptr + consumed >= it_len_q) begin
        it_state    <= IT_IDLE;
        it_ptr      <= '0;
        it_len_q    <= '0;
        it_active_q <= 1'b0;
      end else begin
        it_ptr <= it_ptr + consumed;
      end
    end
  end

  assign it_active = it_active_q;
`else
  logic unused_it;

  assign unused_it = ^{it_load, it_cond, it_len, it_then};
  assign eff_cond  = ev_cond;
  assign it_active = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_done <= '0;
      ev_pass <= '0;
    end else begin
      ev_done <= ev_valid;
      ev_pass <= ev_valid & lane_pass;
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Scoreboard bench for cond_exec_unit (LANES=2); IT checks follow COND_IT_BLOCK_EN.
module tb_cond_exec_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_we;
  logic [3:0] flag_mask;
  logic [3:0] flag_in;
  logic [3:0] status_out;
  logic [1:0] ev_valid;
  logic [7:0] ev_cond;
  logic [1:0] ev_done;
  logic [1:0] ev_pass;
  logic       it_load;
  logic [3:0] it_cond;
  logic [1:0] it_len;
  logic [3:0] it_then;
  logic       it_active;

  typedef struct {
    logic [1:0] done;
    logic [1:0] pass;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [3:0] c0, c1, f4;
  logic       v1;

  always #5 clk = ~clk;

  cond_exec_unit #(.LANES(2), .IT_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flag_we    (flag_we),
    .flag_mask  (flag_mask),
    .flag_in    (flag_in),
    .status_out (status_out),
    .ev_valid   (ev_valid),
    .ev_cond    (ev_cond),
    .ev_done    (ev_done),
    .ev_pass    (ev_pass),
    .it_load    (it_load),
    .it_cond    (it_cond),
    .it_len     (it_len),
    .it_then    (it_then),
    .it_active  (it_active)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Independent reference: codes come in complementary pairs.
  function automatic logic ref_pass(input logic [3:0] code, input logic [3:0] f);
    logic z, c, n, v, b;
    z = f[3]; c = f[2]; n = f[1]; v = f[0];
    case (code[3:1])
      3'd0:    b = z;
      3'd1:    b = c;
      3'd2:    b = n;
      3'd3:    b = v;
      3'd4:    b = c & ~z;
      3'd5:    b = (n == v);
      3'd6:    b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return b ^ code[0];
  endfunction

  task automatic cycle(input string tag, input logic [1:0] ed, input logic [1:0] ep);
    exp_t e;
    exp_q.push_back('{done: ed, pass: ep});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_done"}, 8'(ev_done), 8'(e.done));
    check({tag, "_pass"}, 8'(ev_pass), 8'(e.pass));
  endtask

  task automatic set_status(input logic [3:0] f);
    flag_we = 1'b1; flag_mask = 4'hF; flag_in = f; ev_valid = 2'b00;
    cycle("wr", 2'b00, 2'b00);
    flag_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flag_we = 1'b0; flag_mask = 4'h0; flag_in = 4'h0;
    ev_valid = 2'b00; ev_cond = 8'h00;
    it_load = 1'b0; it_cond = 4'h0; it_len = 2'd0; it_then = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_status", 8'(status_out), 8'h0);
    check("rst_done", 8'(ev_done), 8'h0);
    check("rst_pass", 8'(ev_pass), 8'h0);
    check("rst_active", 8'(it_active), 8'h0);
    rst = 1'b0;

    // Full write then EQ/NE on the new status.
    set_status(4'b1000);
    check("wr_status", 8'(status_out), 8'h8);
    ev_valid = 2'b11; ev_cond = {4'd1, 4'd0};
    cycle("eq_ne", 2'b11, 2'b01);

    // Masked write in the same cycle as an evaluation sees the old status.
    set_status(4'b0000);
    flag_we = 1'b1; flag_mask = 4'b1000; flag_in = 4'b1111;
    ev_valid = 2'b01; ev_cond = {4'd0, 4'd0};
    cycle("prewrite", 2'b01, 2'b00);
    flag_we = 1'b0;
    check("mask_status", 8'(status_out), 8'h8);
    cycle("postwrite", 2'b01, 2'b01);
    flag_we = 1'b1; flag_mask = 4'b0011; flag_in = 4'b0101; ev_valid = 2'b00;
    cycle("mask2", 2'b00, 2'b00);
    flag_we = 1'b0;
    check("mask2_status", 8'(status_out), 8'h9);

    // Every code over every flag value; lane1 carries the complement code and is sometimes idle.
    for (int f = 0; f < 16; f++) begin
      f4 = 4'(f);
      set_status(f4);
      check("sweep_status", 8'(status_out), 8'(f4));
      for (int c = 0; c < 16; c++) begin
        c0 = 4'(c);
        c1 = 4'(15 - c);
        v1 = (c % 3) != 0;
        ev_valid = {v1, 1'b1};
        ev_cond  = {c1, c0};
        cycle("sweep", {v1, 1'b1}, {v1 & ref_pass(c1, f4), ref_pass(c0, f4)});
      end
    end

`ifdef COND_IT_BLOCK_EN
    set_status(4'b1000);
    // EQ block of 4, pattern then/else/then/else, lanes' own codes are NV.
    it_load = 1'b1; it_cond = 4'd0; it_len = 2'd3; it_then = 4'b0101; ev_valid = 2'b00;
    cycle("it4_load", 2'b00, 2'b00);
    it_load = 1'b0;
    check("it4_active0", 8'(it_active), 8'h1);
    ev_valid = 2'b11; ev_cond = {4'd15, 4'd15};
    cycle("it4_a", 2'b11, 2'b01);
    check("it4_active1", 8'(it_active), 8'h1);
    cycle("it4_b", 2'b11, 2'b01);
    check("it4_active2", 8'(it_active), 8'h0);

    // 3-slot block: lane1 alone takes slot0, then both lanes take slots 1 and 2.
    it_load = 1'b1; it_len = 2'd2; it_then = 4'b0001; ev_valid = 2'b00;
    cycle("it3_load", 2'b00, 2'b00);
    it_load = 1'b0;
    ev_valid = 2'b10; ev_cond = {4'd14, 4'd14};
    cycle("it3_a", 2'b10, 2'b10);
    ev_valid = 2'b11;
    cycle("it3_b", 2'b11, 2'b00);
    check("it3_active", 8'(it_active), 8'h0);

    // 1-slot block: lane1 overflows and uses its own AL.
    it_load = 1'b1; it_len = 2'd0; it_then = 4'b0000; ev_valid = 2'b00;
    cycle("it1_load", 2'b00, 2'b00);
    it_load = 1'b0;
    ev_valid = 2'b11;
    cycle("it1_ovf", 2'b11, 2'b10);
    check("it1_active", 8'(it_active), 8'h0);

    // Reload mid-block: load-cycle lanes still use the old block.
    it_load = 1'b1; it_len = 2'd3; it_then = 4'b0000; ev_valid = 2'b00;
    cycle("rl_load", 2'b00, 2'b00);
    it_load = 1'b0; ev_valid = 2'b01;
    cycle("rl_a", 2'b01, 2'b00);
    it_load = 1'b1; it_len = 2'd0; it_then = 4'b0001;
    cycle("rl_b", 2'b01, 2'b00);
    it_load = 1'b0; ev_valid = 2'b11;
    cycle("rl_c", 2'b11, 2'b11);
    check("rl_active", 8'(it_active), 8'h0);

    // Reset mid-block clears state and results without waiting for a clock.
    it_load = 1'b1; it_len = 2'd3; it_then = 4'b1111; ev_valid = 2'b00;
    cycle("rs_load", 2'b00, 2'b00);
    it_load = 1'b0; ev_valid = 2'b11;
    cycle("rs_a", 2'b11, 2'b11);
    rst = 1'b1;
    #1;
    check("rs_active", 8'(it_active), 8'h0);
    check("rs_done", 8'(ev_done), 8'h0);
    check("rs_status", 8'(status_out), 8'h0);
`else
    // Without the sequencer it_load is ignored.
    set_status(4'b1000);
    it_load = 1'b1; it_cond = 4'd0; it_len = 2'd3; it_then = 4'b0000;
    ev_valid = 2'b11; ev_cond = {4'd14, 4'd0};
    cycle("noit_a", 2'b11, 2'b11);
    it_load = 1'b0;
    check("noit_active", 8'(it_active), 8'h0);
    cycle("noit_b", 2'b11, 2'b11);
    rst = 1'b1;
    #1;
    check("rs_done", 8'(ev_done), 8'h0);
    check("rs_pass", 8'(ev_pass), 8'h0);
    check("rs_status", 8'(status_out), 8'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cond_exec_unit.md
# cond_exec_unit

Condition-execution unit for the core's issue stage: owns the 4-bit status register, accepts masked flag updates from the ALU, and evaluates up to LANES condition codes per cycle with a registered pass/fail result. An optional IT-block sequencer predicates up to four following instructions from a single loaded condition and then/else pattern. Replaces the standalone combinational condition check used by the single-issue pipeline.

## Interface
- LANES, 2, number of parallel condition-evaluation lanes (1..4)
- IT_MAX, 4, maximum IT-block length (fixed at 4 for this generation)

- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flag_we  in  1  status register write strobe
- flag_mask  in  4  per-bit write enable, same bit order as flag_in
- flag_in  in  4  new flags, {Z,C,N,V} = bits [3:0]
- status_out  out  4  current status register, {Z,C,N,V}
- ev_valid  in  LANES  lane i carries an instruction this cycle
- ev_cond  in  4*LANES  lane i condition code at [4i+3:4i]
- ev_done  out  LANES  registered copy of ev_valid
- ev_pass  out  LANES  registered condition result, 0 when lane not done
- it_load  in  1  start IT block
- it_cond  in  4  IT base condition
- it_len  in  2  block length minus one (0 = 1 instr, 3 = 4 instrs)
- it_then  in  4  slot k uses it_cond when bit k = 1, inverted condition when 0
- it_active  out  1  IT block in progress

## Operation
- Codes: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~C|Z; 10 GE N==V; 11 LT N!=V; 12 GT ~Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
- Inverted condition = code XOR 1; else-slot of AL therefore evaluates as NV (0).
- Flag write: status[b] <= flag_in[b] where flag_mask[b]=1; others hold. flag_we=0 ignores mask.
- Evaluation always uses the registered status (pre-write); a write is visible to lanes one cycle later.
- IT states: IDLE, ACTIVE. IDLE->ACTIVE on it_load: slot pointer 0, remaining = it_len+1, pattern latched.
- ACTIVE: valid lanes consume slots in ascending lane order; lane i with ev_valid takes slot ptr+(count of valid lanes below i) if that slot < remaining, and its ev_cond is overridden by the slot condition. Valid lanes beyond remaining slots use their own ev_cond.
- ptr advances by number of slots consumed; ACTIVE->IDLE when all slots consumed.
- it_load in ACTIVE restarts with the new block; old remaining slots discarded. Lanes in the load cycle use pre-load state.
- Invalid lanes consume nothing; ev_pass forced 0.

## Timing
- Reset: status_out 0000, ev_done 0, ev_pass 0, it_active 0, ptr 0, remaining 0.
- ev_done/ev_pass: 1-cycle latency from ev_valid/ev_cond.
- status_out: updates the cycle after flag_we.
- it_active rises the cycle after it_load, falls the cycle after the last slot is consumed.
- Reset asserted mid-block: immediately IDLE, pending results dropped.
- No backpressure; every valid lane produces exactly one ev_done pulse.

## Configuration
- COND_IT_BLOCK_EN defined: IT sequencer built as above.
- Undefined: no IT state; it_load/it_cond/it_len/it_then ignored, it_active tied 0, every lane evaluates its own ev_cond.

## Structure
- Package cond_pkg: 4-bit condition code constants (EQ..NV), flag bit indices Z=3 C=2 N=1 V=0, IT state encoding.
- Sub-module cond_eval: combinational code+flags -> pass, one instance per lane.
- Status register, IT sequencer and output registers live in cond_exec_unit.

## Test plan
- Reset, then flag_we=1 mask=1111 flag_in=1000; next cycle lane0 EQ -> ev_done=1 ev_pass=1, lane1 NE -> ev_pass=0.
- status=0000, flag_we mask=1000 flag_in=1111 with lane0 EQ same cycle -> ev_pass=0 (pre-write); status_out=1000 next cycle.
- Sweep all 16 codes over all 16 flag values on lane0 -> ev_pass matches table; code 9 with C=1 Z=1 -> 1, code 13 with Z=0 N=1 V=0 -> 1.
- it_load it_cond=EQ it_len=3 it_then=0101, Z=1, LANES=2 both valid for two cycles -> ev_pass 1,0 then 1,0; it_active falls after second cycle.
- it_len=2 block, then cycle with only lane1 valid, then both valid -> lane1 takes slot0, next cycle lanes take slot1,slot2; third-slot-overflow lane uses own code.
- Assert rst while it_active=1 -> it_active=0 and ev_done=0 immediately; without COND_IT_BLOCK_EN it_load has no effect on ev_pass.
